// File: rtl/alu_decoder_muldiv_if.sv
// Decode/execute handshake bundle between the
// ID stage and the ALU decoder with mul/div engine.
interface alu_decoder_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [1:0]       ALUop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [3:0]       ALU_control;
  logic             illegal;
  logic             hilo_sel;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;
  logic             stall;

  modport master (
    output valid, ALUop, funct, rs_val, rt_val,
    input  ALU_control, illegal, hilo_sel,
    input  hilo_out, busy, stall
  );

  modport slave (
    input  valid, ALUop, funct, rs_val, rt_val,
    output ALU_control, illegal, hilo_sel,
    output hilo_out, busy, stall
  );
endinterface

// File: rtl/alu_decoder_muldiv.sv
// ALU control decoder plus iterative mul/div
// engine owning the HI/LO register pair.
module alu_decoder_muldiv #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  alu_decoder_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2-1:0]    acc_q;
  logic             div_q, neg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [3:0] ctl;
  logic       ill, hilo_f, md_f;
  logic       mfhi, mflo, mthi, mtlo;

  // funct/ALUop decode into ALU select and hilo class
  always_comb begin
    ctl    = 4'b0010;
    ill    = 1'b0;
    hilo_f = 1'b0;
    md_f   = 1'b0;
    unique case (bus.ALUop)
      2'b00: ctl = 4'b0010;
      2'b01: ctl = 4'b0110;
      2'b11: ctl = 4'b0010;
      2'b10: begin
        case (bus.funct)
          6'b100000, 6'b100001: ctl = 4'b0010;
          6'b100010, 6'b100011: ctl = 4'b0110;
          6'b100100: ctl = 4'b0000;
          6'b100101: ctl = 4'b0001;
          6'b100110: ctl = 4'b0011;
          6'b100111: ctl = 4'b1100;
          6'b101010: ctl = 4'b0111;
          6'b101011: ctl = 4'b1000;
          6'b000000: ctl = 4'b1001;
          6'b000010: ctl = 4'b1010;
          6'b000011: ctl = 4'b1011;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: begin
            hilo_f = 1'b1;
            md_f   = 1'b1;
          end
          6'b010000, 6'b010001,
          6'b010010, 6'b010011: hilo_f = 1'b1;
          default: begin
            ctl = 4'b1111;
            ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  logic busy, free, accept;

  assign busy   = (state_q != S_IDLE);
  assign free   = bus.valid & !busy;
  assign accept = free & md_f;
  assign mfhi   = free & hilo_f & (bus.funct == 6'b010000);
  assign mthi   = free & hilo_f & (bus.funct == 6'b010001);
  assign mflo   = free & hilo_f & (bus.funct == 6'b010010);
  assign mtlo   = free & hilo_f & (bus.funct == 6'b010011);

  assign bus.ALU_control = ctl;
  assign bus.illegal     = ill;
  assign bus.busy        = busy;
  assign bus.stall       = bus.valid & hilo_f & busy;
  assign bus.hilo_sel    = mfhi | mflo;
  assign bus.hilo_out    = mfhi ? hi_q :
                           mflo ? lo_q : '0;

  // operand magnitudes and result signs at accept
  logic             sgn;
  logic [WIDTH-1:0] ma, mb;

  assign sgn = !bus.funct[0];
  assign ma  = (sgn & bus.rs_val[WIDTH-1]) ?
               -bus.rs_val : bus.rs_val;
  assign mb  = (sgn & bus.rt_val[WIDTH-1]) ?
               -bus.rt_val : bus.rt_val;

  // one shift-add or restoring-subtract step
  logic [WIDTH:0]   msum;
  logic [WIDTH+1:0] dtry;
  logic [W2-1:0]    step;

  always_comb begin
    msum = {1'b0, acc_q[W2-1:WIDTH]} +
           (acc_q[0] ? {1'b0, a_q} : '0);
    dtry = {1'b0, acc_q[W2-1:WIDTH-1]} -
           {2'b00, b_q};
    if (!div_q)
      step = {msum, acc_q[WIDTH-1:1]};
    else if (!dtry[WIDTH+1])
      step = {dtry[WIDTH-1:0],
              acc_q[WIDTH-2:0], 1'b1};
    else
      step = {acc_q[W2-2:0], 1'b0};
  end

  // sign fixup of the finished magnitudes
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = dz_q ? '1 :
           neg_q ? -acc_q[WIDTH-1:0] :
           acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[W2-1:WIDTH] :
           acc_q[W2-1:WIDTH];
  end

  // engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // engine next-state: WIDTH RUN cycles then FIXUP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand latch, iteration datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= CW'(WIDTH - 1);
        div_q  <= bus.funct[1];
        neg_q  <= sgn &
                  (bus.rs_val[WIDTH-1] ^
                   bus.rt_val[WIDTH-1]);
        rneg_q <= sgn & bus.rs_val[WIDTH-1];
        dz_q   <= bus.funct[1] &
                  (bus.rt_val == '0);
        if (bus.funct[1]) begin
          a_q   <= ma;
          b_q   <= mb;
          acc_q <= {{WIDTH{1'b0}}, ma};
        end else begin
          a_q   <= ma;
          b_q   <= mb;
          acc_q <= {{WIDTH{1'b0}}, mb};
        end
      end
      if (state_q == S_RUN) begin
        acc_q <= step;
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_FIXUP) begin
        if (div_q) begin
          hi_q <= rem;
          lo_q <= quo;
        end else begin
          hi_q <= prod[W2-1:WIDTH];
          lo_q <= prod[WIDTH-1:0];
        end
      end
      if (mthi) hi_q <= bus.rs_val;
      if (mtlo) lo_q <= bus.rs_val;
    end
  end
endmodule

// File: tb/tb_alu_decoder_muldiv.sv
// Directed bench for alu_decoder_muldiv:
// decode table, mul/div results, stalls, reset abort.
module tb_alu_decoder_muldiv;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_decoder_muldiv_if #(.WIDTH(W)) bus ();

  alu_decoder_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  task automatic drive(input logic v,
                       input logic [5:0] f,
                       input logic [W-1:0] rs,
                       input logic [W-1:0] rt);
    bus.valid  = v;
    bus.ALUop  = 2'b10;
    bus.funct  = f;
    bus.rs_val = rs;
    bus.rt_val = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept an op, then idle until the engine is free
  task automatic run_op(input logic [5:0] f,
                        input logic [W-1:0] rs,
                        input logic [W-1:0] rt);
    int n;
    drive(1'b1, f, rs, rt);
    tick();
    drive(1'b0, F_MFLO, '0, '0);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != W + 1) begin
      errors++;
      $display("FAIL busy_len f=%b got %0d want %0d",
               f, n, W + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, F_MFLO, '0, '0);
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b/%b want 0/0",
               bus.busy, bus.stall);
    end
    checks++;
    if (bus.hilo_out !== '0) begin
      errors++;
      $display("FAIL reset_hilo got %h want 0",
               bus.hilo_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [1:0] op  [8];
    logic [5:0] fn  [8];
    logic [3:0] ec  [8];
    logic       ei  [8];
    op = '{2'b00, 2'b01, 2'b10, 2'b10,
           2'b10, 2'b10, 2'b10, 2'b11};
    fn = '{6'h00, 6'h00, 6'b100101, 6'b100111,
           6'b101011, 6'b111111, 6'b000011, 6'h3f};
    ec = '{4'b0010, 4'b0110, 4'b0001, 4'b1100,
           4'b1000, 4'b1111, 4'b1011, 4'b0010};
    ei = '{1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.valid = 1'b0;
      bus.ALUop = op[i];
      bus.funct = fn[i];
      #1;
      checks++;
      if (bus.ALU_control !== ec[i] ||
          bus.illegal !== ei[i]) begin
        errors++;
        $display("FAIL decode_%0d got %b/%b want %b/%b",
                 i, bus.ALU_control, bus.illegal,
                 ec[i], ei[i]);
      end
    end
    tick();
  endtask

  task automatic test_mult();
    int n;
    drive(1'b1, F_MULT, 32'hFFFFFFFD, 32'h7);
    tick();
    drive(1'b1, F_MFLO, '0, '0);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL mult_stall got %0d want 33", n);
    end
    checks++;
    if (bus.hilo_out !== 32'hFFFFFFEB ||
        bus.hilo_sel !== 1'b1) begin
      errors++;
      $display("FAIL mult_lo got %h want FFFFFFEB",
               bus.hilo_out);
    end
    drive(1'b1, F_MFHI, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mult_hi got %h want FFFFFFFF",
               bus.hilo_out);
    end
    tick();
  endtask

  task automatic test_div(input logic [5:0] f,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] elo,
                          input logic [W-1:0] ehi);
    run_op(f, a, b);
    drive(1'b1, F_MFLO, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== elo) begin
      errors++;
      $display("FAIL div_lo %h/%h got %h want %h",
               a, b, bus.hilo_out, elo);
    end
    drive(1'b1, F_MFHI, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== ehi) begin
      errors++;
      $display("FAIL div_hi %h/%h got %h want %h",
               a, b, bus.hilo_out, ehi);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    drive(1'b1, F_MULTU, 32'd3, 32'd5);
    tick();
    drive(1'b1, F_MULT, 32'd2, 32'd3);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL b2b_mult_stall got %0d want 33", n);
    end
    tick();
    drive(1'b1, F_MTHI, 32'h1234, '0);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL b2b_mthi_stall got %0d want 33", n);
    end
    tick();
    drive(1'b1, F_MFHI, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== 32'h1234) begin
      errors++;
      $display("FAIL b2b_hi got %h want 00001234",
               bus.hilo_out);
    end
    drive(1'b1, F_MFLO, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== 32'd6) begin
      errors++;
      $display("FAIL b2b_lo got %h want 00000006",
               bus.hilo_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, F_MULT, 32'd7, 32'd9);
    tick();
    drive(1'b0, F_MFLO, '0, '0);
    repeat (10) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy got %b want 1",
               bus.busy);
    end
    drive(1'b1, F_MFLO, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 ||
        bus.hilo_out !== '0) begin
      errors++;
      $display("FAIL rst_mid got %b/%b/%h want 0/0/0",
               bus.busy, bus.stall, bus.hilo_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.stall !== 1'b0 || bus.hilo_out !== '0) begin
      errors++;
      $display("FAIL rst_after_lo got %b/%h want 0/0",
               bus.stall, bus.hilo_out);
    end
    drive(1'b1, F_MFHI, '0, '0);
    #1;
    checks++;
    if (bus.hilo_out !== '0) begin
      errors++;
      $display("FAIL rst_after_hi got %h want 0",
               bus.hilo_out);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 6'h00, '0, '0);
    bus.ALUop = 2'b00;
    test_reset();
    test_decode();
    test_mult();
    test_div(F_DIVU, 32'd100, 32'd7,
             32'h0000000E, 32'h00000002);
    test_div(F_DIV, 32'hFFFFFFF9, 32'h2,
             32'hFFFFFFFD, 32'hFFFFFFFF);
    test_div(F_DIV, 32'd5, 32'd0,
             32'hFFFFFFFF, 32'h00000005);
    test_div(F_DIV, 32'h80000000, 32'hFFFFFFFF,
             32'h80000000, 32'h00000000);
    test_div(F_DIVU, 32'd9, 32'd0,
             32'hFFFFFFFF, 32'h00000009);
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
